stream_fifo: RTL and testbench
==============================

# stream_fifo

Synchronous valid/ready FIFO placed directly upstream of a generated function module such as `tests_fact`. It absorbs bursts of `intN`-wide operands from a producer and presents them one at a time on the same `sync` handshake the generated modules consume, so a producer never stalls while a multi-cycle function is busy. Its input side matches a generated module's output side, so it can equally sit downstream between two generated stages.

## Interface
- `N`, default `` `intN `` (16): data width; `in0`/`out0` are `N` bits (`` `intT `` when `N` = `` `intN ``).
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`.
- `in_valid`  in  1  producer has a word on `in0`.
- `in_ready`  out  1  FIFO can accept a word this cycle.
- `in0`  in  N  write data.
- `out_valid`  out  1  `out0` holds the oldest stored word.
- `out_ready`  in  1  consumer takes `out0` this cycle.
- `out0`  out  N  read data (head of queue).
- `level`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` × `N` register array; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo `DEPTH` with no special case; occupancy counter `count` drives `level`.
- `push` = `in_valid & in_ready`; `pop` = `out_valid & out_ready`.
- `in_ready` = (`count` != `DEPTH`); `out_valid` = (`count` != 0). Both are decoded from registered `count` only and never depend combinationally on `in_valid` or `out_ready`.
- On push: `mem[wp]` ← `in0`; `wp` ← `wp`+1.
- On pop: `rp` ← `rp`+1.
- `count`: +1 on push only; −1 on pop only; unchanged on both or neither.
- `out0` = `mem[rp]`, first-word-fall-through. It is don't-care while `out_valid`=0, but it must not be X after reset: the array is cleared to 0 on reset.
- Full (`count`=`DEPTH`): `in_ready`=0 and no write occurs, even if `out_ready`=1 the same cycle. There is no full-bypass; the slot frees one cycle later.
- Empty (`count`=0): `out_valid`=0. There is no empty-bypass; a word pushed at edge k is first visible at edge k.
- Simultaneous push and pop with 0 < `count` < `DEPTH`: both occur and `count` is held.
- Data order is strictly FIFO; no word is dropped or duplicated.
- `in0` is sampled only on a push edge. While `in_valid`=0, `in0` may change freely.
- Once `out_valid`=1, `out0` stays stable until popped.

## Timing
- Reset values (asserted asynchronously): `in_ready`=1, `out_valid`=0, `out0`=0, `level`=0, `wp`=`rp`=0, array cleared.
- Reset asserted mid-operation discards all contents. The first edge after deassertion may accept a push.
- Latency: a push at rising edge k gives `out_valid`=1 and `out0`=data during cycle k→k+1.
- Throughput: one push and one pop per cycle sustained in steady state.
- `in_ready` drops in the cycle after the edge that fills the last slot. It rises in the cycle after the pop that frees a slot.
- `level` reflects state after the most recent edge.

## Test plan
- Reset: with `reset`=1, check `in_ready`=1, `out_valid`=0, `level`=0, `out0`=0. Then assert `reset` between clock edges and check that outputs clear immediately.
- Fill/drain (`DEPTH`=4): with `out_ready`=0, push 8, 7, 6, 5 → `level`=4 and `in_ready`=0. Pushing 3 while full → ignored. Then set `out_ready`=1 → outputs 8, 7, 6, 5 on consecutive cycles, then `out_valid`=0 and `level`=0.
- Full with `out_ready`=1 and `in_valid`=1: one pop occurs and no push → `level`=3. On the next cycle `in_ready`=1 and the push lands.
- Streaming: `in_valid`=`out_ready`=1 for 20 cycles with an incrementing 0..19 pattern → outputs 0..19 with 1-cycle latency. `level` stays at 1 and pointers wrap cleanly past 3.
- Reset mid-queue: push 1, 2, 3, assert `reset` → `level`=0 and `out_valid`=0. After release, push 9 → next output is 9 with no stale 1, 2 or 3.
- Integration: `stream_fifo` feeding `tests_fact`, push 8 once → `tests_fact` `out0` = 40320 (16'b1001110110000000) within 16 cycles.

Source files
------------

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with first-word-fall-through output and registered flow control.
// Feeds single-word operands to multi-cycle function blocks without stalling the producer.
module stream_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out0,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [LW-1:0] count_q, count_d;
  logic          push, pop;

  // Handshake decode uses only registered occupancy, so no combinational valid->ready path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out0      = mem_q[rp_q];
  assign level     = count_q;

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) begin
      mem_d[wp_q] = in0;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Array is cleared on reset so out0 is never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_stream_fifo;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in0;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out0;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] model_q[$];

  stream_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    check_val({tag, "_level"},     32'(level),     32'(model_q.size()));
    if (model_q.size() != 0)
      check_val({tag, "_out0"}, 32'(out0), 32'(model_q[0]));
  endtask

  // Called at a negedge: apply inputs, model the rising edge, check after it.
  task automatic step(input logic iv, input logic [N-1:0] d, input logic ordy, input string tag);
    bit do_push, do_pop;
    in_valid  = iv;
    in0       = d;
    out_ready = ordy;
    @(posedge clk);
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    check_val("arst_level",     32'(level),     0);
    check_val("arst_out_valid", 32'(out_valid), 0);
    check_val("arst_in_ready",  32'(in_ready),  1);
    check_val("arst_out0",      32'(out0),      0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] drain_exp [4];
    drain_exp[0] = 16'd8; drain_exp[1] = 16'd7; drain_exp[2] = 16'd6; drain_exp[3] = 16'd5;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    out_ready = 1'b0;
    #3;
    check_val("rst_in_ready",  32'(in_ready),  1);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_level",     32'(level),     0);
    check_val("rst_out0",      32'(out0),      0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill, overflow attempt, drain.
    step(1, 16'd8, 0, "fill");
    step(1, 16'd7, 0, "fill");
    step(1, 16'd6, 0, "fill");
    step(1, 16'd5, 0, "fill");
    check_val("full_level", 32'(level), 4);
    check_val("full_in_ready", 32'(in_ready), 0);
    step(1, 16'd3, 0, "push_full");
    check_val("push_full_level", 32'(level), 4);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_data", 32'(out0), 32'(drain_exp[i]));
      step(0, 16'hdead, 1, "drain");
    end
    check_val("drained_out_valid", 32'(out_valid), 0);
    check_val("drained_level", 32'(level), 0);

    // Full with simultaneous push attempt and pop: pop only, then push lands.
    for (int i = 0; i < 4; i++) step(1, 16'(100 + i), 0, "refill");
    step(1, 16'd77, 1, "full_both");
    check_val("full_both_level", 32'(level), 3);
    check_val("full_both_in_ready", 32'(in_ready), 1);
    check_val("full_both_head", 32'(out0), 101);
    step(1, 16'd78, 1, "after_full");
    check_val("after_full_level", 32'(level), 3);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, "empty_out");

    // Streaming: one in, one out per cycle, pointers wrap repeatedly.
    for (int i = 0; i < 20; i++) begin
      step(1, 16'(i), 1, "stream");
      check_val("stream_out", 32'(out0), 32'(i));
      check_val("stream_level", 32'(level), 1);
    end
    step(0, 16'h0, 1, "stream_end");
    check_val("stream_end_level", 32'(level), 0);

    // Reset mid-queue discards contents.
    step(1, 16'd1, 0, "pre_rst");
    step(1, 16'd2, 0, "pre_rst");
    step(1, 16'd3, 0, "pre_rst");
    async_reset_pulse();
    step(1, 16'd9, 0, "post_rst");
    check_val("post_rst_out0", 32'(out0), 9);
    check_val("post_rst_level", 32'(level), 1);
    step(0, 16'h0, 1, "post_rst_pop");
    check_val("post_rst_empty", 32'(out_valid), 0);

    // Random traffic with shifting producer/consumer bias.
    for (int i = 0; i < 600; i++) begin
      int bias_v, bias_r;
      bias_v = (i / 100) % 3;
      bias_r = ((i / 100) + 1) % 3;
      step(($urandom_range(0, 3) > bias_v), 16'($urandom),
           ($urandom_range(0, 3) > bias_r), "rand");
      if (i == 333) async_reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
